conv_window_accumulator: RTL and testbench
==========================================

Name: conv_window_accumulator

Overview:
Sits directly downstream of the 4x4-bit product stage in the CNN single-layer datapath. It sums the 8-bit unsigned products of one convolution window (image pixel x filter weight, N_TAPS of them) into one output pixel. It raises a one-cycle valid strobe when the sum is ready. Window start, accumulation and completion are sequenced by a small FSM with a tap counter.

Parameters:
N_TAPS, 9, products per window (3x3 filter); legal range 2..255
DIN_W, 8, product width (matches 4-bit x 4-bit product)
OUT_W, 12, accumulator/result width; must be >= DIN_W + ceil(log2(N_TAPS))

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
Start  input  1  one-cycle pulse: begin a new window (clears accumulator)
din_valid  input  1  din carries a valid product this cycle
din  input  DIN_W  unsigned product from multiplier stage
dout  output  OUT_W  window sum; holds last completed result
dout_valid  output  1  one-cycle strobe, dout updated this cycle
busy  output  1  window in progress (state ACC)
tap_cnt  output  8  products accepted in current window

Behaviour:
- Reset (rst_n=0, async): state=IDLE, acc=0, tap_cnt=0, dout=0, dout_valid=0, busy=0. Reset mid-window discards the partial sum with no dout_valid.
- States: IDLE, ACC, DONE. busy=1 only in ACC. dout_valid=1 only in DONE.
- IDLE: din_valid without Start is ignored. Start=1 -> ACC, acc cleared.
  - If din_valid=1 in the same cycle as Start, din is the first tap: acc=din, tap_cnt=1.
  - Otherwise acc=0, tap_cnt=0.
- ACC, din_valid=1: acc=acc+din (zero-extended to OUT_W), tap_cnt+1.
  - When the accepted tap is tap number N_TAPS, go to DONE on the same edge.
  - On that edge: dout=acc+din, tap_cnt=N_TAPS.
- ACC, din_valid=0: hold. No timeout; gaps of any length are allowed.
- Start in ACC: abort and restart. Same rules as Start in IDLE; the old partial sum is lost and no dout_valid is produced for it.
  - Start and din_valid together in ACC: din becomes tap 1 of the new window. It is not added to the old window.
- DONE (exactly one cycle): dout_valid=1, dout stable.
  - Next state is IDLE.
  - If Start=1 in DONE, next state is ACC with the same first-tap rule (back-to-back windows, no dead cycle).
  - din_valid without Start in DONE is ignored.
- Latency: dout_valid is asserted in the cycle after the edge that accepted the N_TAPS-th product.
- Throughput: one window per N_TAPS cycles plus 1 when products are contiguous, using Start in DONE.
- dout holds its value through IDLE and the next window until the next DONE.
- Arithmetic: unsigned, no saturation. With legal OUT_W, overflow cannot occur (9 x 225 = 2025 < 4096). If OUT_W is misparameterized, the sum wraps modulo 2^OUT_W.
- tap_cnt resets to 0 on entry to IDLE from DONE. It reads N_TAPS during DONE.

Test Plan:
- Reset, then Start plus 9 contiguous din=225 -> dout_valid one cycle after the 9th, dout=2025, busy low in DONE.
- Start, then din=1..9 with 2-cycle gaps between taps -> dout=45. No dout_valid before the 9th tap. tap_cnt steps 1..9.
- Start with din_valid=1 and din=10 in the same cycle, then 8 x din=0 -> dout=10 (first-tap rule).
- Abort: Start, 4 x din=100, then Start with din=5, then 8 x din=1 -> single dout_valid, dout=13. The old partial sum of 400 is never output.
- Back-to-back: Start asserted in the DONE cycle of a window summing to 81 (9 x 9). Next window 9 x 2 -> dout_valid pulses give 81 then 18, with no gap cycle. din_valid in IDLE without Start is ignored.
- Async reset after 5 taps -> outputs 0 immediately and no dout_valid. A fresh window of 9 x 3 afterwards -> dout=27.

Source files
------------

// File: rtl/conv_window_accumulator_if.sv
// Handshake bundle between the product stage and the window accumulator.
// The master side drives products and window starts; the slave side returns the window sum.
interface conv_window_accumulator_if #(
  parameter int DIN_W = 8,
  parameter int OUT_W = 12
);
  logic             Start;
  logic             din_valid;
  logic [DIN_W-1:0] din;
  logic [OUT_W-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic [7:0]       tap_cnt;

  modport master (
    output Start, din_valid, din,
    input  dout, dout_valid, busy, tap_cnt
  );

  modport slave (
    input  Start, din_valid, din,
    output dout, dout_valid, busy, tap_cnt
  );
endinterface

// File: rtl/conv_window_accumulator.sv
// Sums the N_TAPS unsigned products of one convolution window into one output pixel.
// Sequenced by an IDLE/ACC/DONE FSM; dout_valid strobes for exactly one cycle per completed window.
module conv_window_accumulator #(
  parameter int N_TAPS = 9,
  parameter int DIN_W  = 8,
  parameter int OUT_W  = 12
) (
  input logic                       clk,
  input logic                       rst_n,
  conv_window_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(N_TAPS - 1);
  localparam logic [7:0] FULL_CNT = 8'(N_TAPS);

  state_t           state;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] din_ext;
  logic [OUT_W-1:0] sum;
  logic [OUT_W-1:0] dout_r;
  logic             dout_valid_r;
  logic             busy_r;
  logic [7:0]       tap_cnt_r;

  assign din_ext = {{(OUT_W - DIN_W){1'b0}}, bus.din};
  assign sum     = acc + din_ext;

  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.busy       = busy_r;
  assign bus.tap_cnt    = tap_cnt_r;

  // NOTE: all state updates use non-blocking assignments so every register samples
  // pre-edge values; blocking here would let sum/tap_cnt see same-edge updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      tap_cnt_r    <= '0;
    end else begin
      dout_valid_r <= 1'b0;
      if (bus.Start) begin
        // Start wins in every state: a product arriving with it is tap 1 of the new window.
        state     <= ACC;
        busy_r    <= 1'b1;
        acc       <= bus.din_valid ? din_ext : '0;
        tap_cnt_r <= bus.din_valid ? 8'd1 : 8'd0;
      end else begin
        case (state)
          IDLE: begin
            busy_r <= 1'b0;
          end
          ACC: begin
            if (bus.din_valid) begin
              if (tap_cnt_r == LAST_CNT) begin
                state        <= DONE;
                busy_r       <= 1'b0;
                dout_r       <= sum;
                dout_valid_r <= 1'b1;
                tap_cnt_r    <= FULL_CNT;
              end else begin
                acc       <= sum;
                tap_cnt_r <= tap_cnt_r + 8'd1;
              end
            end
          end
          DONE: begin
            state     <= IDLE;
            busy_r    <= 1'b0;
            tap_cnt_r <= '0;
          end
          default: begin
            state     <= IDLE;
            busy_r    <= 1'b0;
            tap_cnt_r <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_window_accumulator.sv
// Directed bench for conv_window_accumulator: contiguous, gapped, first-tap, abort,
// back-to-back and async-reset windows, each with hand-computed sums.
module tb_conv_window_accumulator;

  localparam int N_TAPS = 9;
  localparam int DIN_W  = 8;
  localparam int OUT_W  = 12;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   valid_count;

  conv_window_accumulator_if #(.DIN_W(DIN_W), .OUT_W(OUT_W)) bus ();

  conv_window_accumulator #(.N_TAPS(N_TAPS), .DIN_W(DIN_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts dout_valid pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.dout_valid === 1'b1) valid_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: drive inputs, wait for the edge, sample #1 after it, then idle the inputs.
  task automatic cycle(input logic s, input logic v, input logic [DIN_W-1:0] d);
    bus.Start     = s;
    bus.din_valid = v;
    bus.din       = d;
    @(posedge clk);
    #1;
    bus.Start     = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.Start     = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    #12;
    n_checks++;
    if (bus.dout !== 12'd0) begin n_fail++; $display("FAIL reset_dout: got %0d expected 0", bus.dout); end
    n_checks++;
    if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid: got %b expected 0", bus.dout_valid); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++;
    if (bus.tap_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_tap_cnt: got %0d expected 0", bus.tap_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_contiguous();
    valid_count = 0;
    cycle(1'b1, 1'b0, 8'd0);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.tap_cnt !== 8'd0) begin
      n_fail++; $display("FAIL contig_start: busy=%b tap_cnt=%0d expected busy=1 tap_cnt=0", bus.busy, bus.tap_cnt);
    end
    for (int i = 1; i <= N_TAPS; i++) begin
      cycle(1'b0, 1'b1, 8'd225);
      if (i == N_TAPS - 1) begin
        n_checks++;
        if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL contig_early_valid: got %b expected 0", bus.dout_valid); end
      end
    end
    n_checks++;
    if (bus.dout_valid !== 1'b1) begin n_fail++; $display("FAIL contig_valid: got %b expected 1", bus.dout_valid); end
    n_checks++;
    if (bus.dout !== 12'd2025) begin n_fail++; $display("FAIL contig_dout: got %0d expected 2025", bus.dout); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL contig_busy_done: got %b expected 0", bus.busy); end
    n_checks++;
    if (bus.tap_cnt !== 8'd9) begin n_fail++; $display("FAIL contig_tap_cnt_done: got %0d expected 9", bus.tap_cnt); end
    cycle(1'b0, 1'b0, 8'd0);
    n_checks++;
    if (bus.dout_valid !== 1'b0 || bus.tap_cnt !== 8'd0 || bus.dout !== 12'd2025) begin
      n_fail++;
      $display("FAIL contig_idle: valid=%b tap_cnt=%0d dout=%0d expected 0/0/2025", bus.dout_valid, bus.tap_cnt, bus.dout);
    end
    n_checks++;
    if (valid_count !== 1) begin n_fail++; $display("FAIL contig_pulses: got %0d expected 1", valid_count); end
  endtask

  task automatic test_gaps();
    int bad_cnt;
    int early;
    bad_cnt = 0;
    early   = 0;
    valid_count = 0;
    cycle(1'b1, 1'b0, 8'd0);
    for (int i = 1; i <= N_TAPS; i++) begin
      cycle(1'b0, 1'b1, 8'(i));
      if (bus.tap_cnt !== 8'(i)) bad_cnt++;
      if (i < N_TAPS) begin
        if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b1) early++;
        for (int g = 0; g < 2; g++) begin
          cycle(1'b0, 1'b0, 8'd0);
          if (bus.dout_valid !== 1'b0 || bus.tap_cnt !== 8'(i)) early++;
        end
      end
    end
    n_checks++;
    if (bad_cnt != 0) begin n_fail++; $display("FAIL gaps_tap_cnt: %0d wrong tap_cnt steps, expected 0", bad_cnt); end
    n_checks++;
    if (early != 0) begin n_fail++; $display("FAIL gaps_hold: %0d bad gap/early cycles, expected 0", early); end
    n_checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 12'd45) begin
      n_fail++; $display("FAIL gaps_dout: valid=%b dout=%0d expected 1/45", bus.dout_valid, bus.dout);
    end
    cycle(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_first_tap();
    cycle(1'b1, 1'b1, 8'd10);
    n_checks++;
    if (bus.tap_cnt !== 8'd1 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL first_tap_cnt: tap_cnt=%0d busy=%b expected 1/1", bus.tap_cnt, bus.busy);
    end
    for (int i = 0; i < N_TAPS - 1; i++) cycle(1'b0, 1'b1, 8'd0);
    n_checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 12'd10) begin
      n_fail++; $display("FAIL first_tap_dout: valid=%b dout=%0d expected 1/10", bus.dout_valid, bus.dout);
    end
    cycle(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_abort();
    valid_count = 0;
    cycle(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'd100);
    n_checks++;
    if (bus.tap_cnt !== 8'd4) begin n_fail++; $display("FAIL abort_partial_cnt: got %0d expected 4", bus.tap_cnt); end
    cycle(1'b1, 1'b1, 8'd5);
    n_checks++;
    if (bus.tap_cnt !== 8'd1 || bus.dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_restart: tap_cnt=%0d valid=%b expected 1/0", bus.tap_cnt, bus.dout_valid);
    end
    for (int i = 0; i < N_TAPS - 1; i++) cycle(1'b0, 1'b1, 8'd1);
    n_checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 12'd13) begin
      n_fail++; $display("FAIL abort_dout: valid=%b dout=%0d expected 1/13", bus.dout_valid, bus.dout);
    end
    cycle(1'b0, 1'b0, 8'd0);
    n_checks++;
    if (valid_count !== 1) begin n_fail++; $display("FAIL abort_pulses: got %0d expected 1", valid_count); end
  endtask

  task automatic test_back_to_back();
    valid_count = 0;
    cycle(1'b0, 1'b1, 8'd50);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.tap_cnt !== 8'd0) begin
      n_fail++; $display("FAIL idle_ignore: busy=%b tap_cnt=%0d expected 0/0", bus.busy, bus.tap_cnt);
    end
    cycle(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < N_TAPS; i++) cycle(1'b0, 1'b1, 8'd9);
    n_checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 12'd81) begin
      n_fail++; $display("FAIL b2b_first_dout: valid=%b dout=%0d expected 1/81", bus.dout_valid, bus.dout);
    end
    cycle(1'b1, 1'b1, 8'd2);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.tap_cnt !== 8'd1 || bus.dout_valid !== 1'b0 || bus.dout !== 12'd81) begin
      n_fail++;
      $display("FAIL b2b_restart: busy=%b tap_cnt=%0d valid=%b dout=%0d expected 1/1/0/81",
               bus.busy, bus.tap_cnt, bus.dout_valid, bus.dout);
    end
    for (int i = 0; i < N_TAPS - 1; i++) cycle(1'b0, 1'b1, 8'd2);
    n_checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 12'd18) begin
      n_fail++; $display("FAIL b2b_second_dout: valid=%b dout=%0d expected 1/18", bus.dout_valid, bus.dout);
    end
    cycle(1'b0, 1'b1, 8'd7);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.tap_cnt !== 8'd0 || bus.dout !== 12'd18) begin
      n_fail++; $display("FAIL done_ignore: busy=%b tap_cnt=%0d dout=%0d expected 0/0/18", bus.busy, bus.tap_cnt, bus.dout);
    end
    n_checks++;
    if (valid_count !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", valid_count); end
  endtask

  task automatic test_async_reset();
    valid_count = 0;
    cycle(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'd40);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.dout !== 12'd0 || bus.tap_cnt !== 8'd0 || bus.busy !== 1'b0 || bus.dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: dout=%0d tap_cnt=%0d busy=%b valid=%b expected 0/0/0/0",
               bus.dout, bus.tap_cnt, bus.busy, bus.dout_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < N_TAPS; i++) cycle(1'b0, 1'b1, 8'd3);
    n_checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 12'd27) begin
      n_fail++; $display("FAIL post_reset_dout: valid=%b dout=%0d expected 1/27", bus.dout_valid, bus.dout);
    end
    cycle(1'b0, 1'b0, 8'd0);
    n_checks++;
    if (valid_count !== 1) begin n_fail++; $display("FAIL post_reset_pulses: got %0d expected 1", valid_count); end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    valid_count = 0;
    test_reset();
    test_contiguous();
    test_gaps();
    test_first_tap();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
